pc_control: RTL and testbench
=============================

Name: pc_control

Overview:
- Program-counter and control-flow stage of the 16-bit single-issue core.
- Sits directly downstream of the ALU: consumes the registered ALU condition flags {V,N,Z} plus the current instruction word.
- Resolves B/BR/HLT, holds the PC register, and drives the fetch address.
- Provides PC+2 to the writeback mux for PCS.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low: rst=0 resets immediately, independent of clk.
- instr  in  16  current instruction word; [15:12] opcode, [11:9] ccc, [8:0] imm9, [7:4] rs field.
- instr_valid  in  1  instr is valid this cycle.
- stall  in  1  hazard/memory stall; hold all state.
- flags  in  3  ALU flags: [2]=V, [1]=N, [0]=Z.
- rs_data  in  16  register-file read of rs, used as BR target.
- pc  out  16  current fetch address (registered).
- pc_plus2  out  16  pc+2, combinational, modulo 2^16.
- branch_taken  out  1  registered one-cycle pulse: the previous accepted instruction redirected the PC.
- halt  out  1  registered; high while in HALT.
- fetch_req  out  1  high in RUN, low in HALT.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=RUN, halt=0, branch_taken=0.
- States:
  - RUN: processor executes.
  - HALT: terminal; exits only on reset.
- Accept condition, evaluated per rising clk in RUN: `accept = instr_valid & ~stall`.
  - stall has priority over instr_valid.
  - When not accepted: pc, state and halt hold; branch_taken=0.
- On accept, decode instr[15:12]:
  - 4'b1100 B: if cond true, pc <= pc+2 + (sext(imm9)<<1) and branch_taken<=1. Otherwise pc <= pc+2.
  - 4'b1101 BR: if cond true, pc <= {rs_data[15:1],1'b0} and branch_taken<=1. The odd bit is silently cleared. Otherwise pc <= pc+2.
  - 4'b1111 HLT: state<=HALT, halt<=1, pc holds the HLT address, branch_taken<=0.
  - All other opcodes, including PCS (4'b1110): pc <= pc+2, branch_taken<=0.
- Condition ccc, evaluated on flags sampled in the same cycle:
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GTE: Z | (~Z & ~N)
  - 101 LTE: N | Z
  - 110 OV: V
  - 111 always
- Arithmetic: all PC math is 16-bit unsigned and wraps modulo 2^16. imm9 is two's complement, giving a range of -256..+255 words.
- In HALT:
  - Inputs are ignored, including instr_valid=1 with B/BR.
  - pc is frozen, fetch_req=0, halt stays 1.
- Latency: target visible on pc one cycle after acceptance. branch_taken is high for exactly that one cycle.
- flags unknown (X) with a non-branch opcode must not affect pc.
- Reset asserted mid-operation, including in HALT or during stall, returns to the reset state immediately. Operation resumes on the first clk edge after rst=1.

Decomposition:
- Shared package contains:
  - Opcode constants: OP_B=4'hC, OP_BR=4'hD, OP_PCS=4'hE, OP_HLT=4'hF.
  - ccc constants: CC_NE…CC_UNCOND.
  - Flag index constants: FLAG_Z=0, FLAG_N=1, FLAG_V=2.
  - State enum: {ST_RUN, ST_HALT}.
- One sub-module: branch_cond. Purely combinational: inputs ccc[2:0] and flags[2:0], output take.

Test Plan:
- Reset check: assert rst=0 between clock edges → pc=16'h0000, halt=0 with no clk edge. Release, then 3 accepted ADDs → pc=0x0006, branch_taken=0.
- B EQ taken:
  - Stimulus: pc=0x0010, instr=16'hC3FE (ccc=001, imm9=-2), Z=1.
  - Response: next pc=0x000E, branch_taken=1 for one cycle.
  - Repeat with Z=0 → pc=0x0012.
- Wrap-around: pc=0xFFFE with unconditional B imm9=+1 → pc=0x0002. A non-branch at 0xFFFE → pc=0x0000.
- BR target: ccc=111, rs_data=0x1235 → pc=0x1234. Also sweep all 8 ccc × 8 flag combos against the condition table above.
- Stall priority: stall=1 with instr_valid=1 for 3 cycles → pc unchanged, branch_taken=0. Release → single advance.
- HLT:
  - HLT accepted at pc=0x0040 → next cycle halt=1, fetch_req=0, pc=0x0040.
  - Follow with B unconditional → pc stays 0x0040.
  - rst=0 → pc=0x0000, halt=0.

Source files
------------

// File: rtl/pc_control_pkg.sv
// Shared encodings, state type and helpers for the PC / control-flow stage.
package pc_control_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned CC_W    = 3;
  localparam int unsigned IMM_W   = 9;
  localparam int unsigned FLAG_W  = 3;

  localparam logic [OPC_W-1:0] OP_B   = 4'hC;
  localparam logic [OPC_W-1:0] OP_BR  = 4'hD;
  localparam logic [OPC_W-1:0] OP_PCS = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  localparam logic [CC_W-1:0] CC_NE     = 3'd0;
  localparam logic [CC_W-1:0] CC_EQ     = 3'd1;
  localparam logic [CC_W-1:0] CC_GT     = 3'd2;
  localparam logic [CC_W-1:0] CC_LT     = 3'd3;
  localparam logic [CC_W-1:0] CC_GTE    = 3'd4;
  localparam logic [CC_W-1:0] CC_LTE    = 3'd5;
  localparam logic [CC_W-1:0] CC_OV     = 3'd6;
  localparam logic [CC_W-1:0] CC_UNCOND = 3'd7;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 2;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Branch-relevant view of the instruction word.
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [CC_W-1:0]  ccc;
    logic [IMM_W-1:0] imm9;
  } instr_t;

  // Word offset of imm9 converted to a byte offset, sign-extended to PC width.
  function automatic logic [PC_W-1:0] branch_offset(input logic [IMM_W-1:0] imm9);
    return {{(PC_W-IMM_W-1){imm9[IMM_W-1]}}, imm9, 1'b0};
  endfunction

endpackage

// File: rtl/pc_control_branch_cond.sv
// Evaluates a 3-bit branch condition code against the ALU flags {V,N,Z}.
module branch_cond
  import pc_control_pkg::*;
(
  input  logic [CC_W-1:0]   ccc,
  input  logic [FLAG_W-1:0] flags,
  output logic              take
);

  logic z;
  logic n;
  logic v;

  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];

  always_comb begin
    take = 1'b0;
    case (ccc)
      CC_NE:     take = ~z;
      CC_EQ:     take = z;
      CC_GT:     take = ~z & ~n;
      CC_LT:     take = n;
      CC_GTE:    take = z | (~z & ~n);
      CC_LTE:    take = n | z;
      CC_OV:     take = v;
      CC_UNCOND: take = 1'b1;
      default:   take = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_control.sv
// Program counter and control-flow resolution (B/BR/HLT) for the 16-bit core.
module pc_control
  import pc_control_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  input  logic               stall,
  input  logic [FLAG_W-1:0]  flags,
  input  logic [PC_W-1:0]    rs_data,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus2,
  output logic               branch_taken,
  output logic               halt,
  output logic               fetch_req
);

  state_e          state;
  state_e          state_d;
  logic [PC_W-1:0] pc_d;
  logic            halt_d;
  logic            taken_d;
  logic            take;
  instr_t          ins;

  assign ins      = instr;
  assign pc_plus2 = pc + PC_W'(2);
  assign fetch_req = (state == ST_RUN);

  branch_cond u_branch_cond (
    .ccc   (ins.ccc),
    .flags (flags),
    .take  (take)
  );

  // State and PC registers; everything holds unless the next-state logic says otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_RUN;
      pc           <= RESET_PC;
      halt         <= 1'b0;
      branch_taken <= 1'b0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      halt         <= halt_d;
      branch_taken <= taken_d;
    end
  end

  // Next-state decode; only accepted instructions in RUN can change anything.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    halt_d  = halt;
    taken_d = 1'b0;
    case (state)
      ST_RUN: begin
        if (instr_valid && !stall) begin
          case (ins.opcode)
            OP_B: begin
              if (take) begin
                pc_d    = pc_plus2 + branch_offset(ins.imm9);
                taken_d = 1'b1;
              end else begin
                pc_d = pc_plus2;
              end
            end
            OP_BR: begin
              if (take) begin
                // Targets are halfword aligned; an odd register value is silently rounded down.
                pc_d    = rs_data & ~PC_W'(1);
                taken_d = 1'b1;
              end else begin
                pc_d = pc_plus2;
              end
            end
            OP_HLT: begin
              state_d = ST_HALT;
              halt_d  = 1'b1;
            end
            default: pc_d = pc_plus2;
          endcase
        end
      end
      ST_HALT: begin
        halt_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        halt_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_control.sv
// Directed vector bench for pc_control: table of single-cycle cases plus multi-cycle sequences.
module tb_pc_control;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic [2:0]  flags;
  logic [15:0] rs_data;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        branch_taken;
  logic        halt;
  logic        fetch_req;

  int n_cmp;
  int n_err;
  logic [15:0] exp_pc;

  typedef struct {
    logic [15:0] instr;
    logic        valid;
    logic        stall;
    logic [2:0]  flags;
    logic [15:0] rs_data;
    logic [15:0] exp_pc;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[17];

  pc_control #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .flags        (flags),
    .rs_data      (rs_data),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .branch_taken (branch_taken),
    .halt         (halt),
    .fetch_req    (fetch_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, clock it, and sample just after the edge.
  task automatic step(input logic [15:0] i, input logic v, input logic s,
                      input logic [2:0] f, input logic [15:0] r);
    instr       = i;
    instr_valid = v;
    stall       = s;
    flags       = f;
    rs_data     = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond_ref(input logic [2:0] c, input logic [2:0] f);
    logic v, n, z;
    v = f[2];
    n = f[1];
    z = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;

    // {instr, valid, stall, flags, rs_data, expected pc after edge, expected branch_taken}
    vecs[0]  = '{16'hDE00, 1'b1, 1'b0, 3'b000, 16'h0010, 16'h0010, 1'b1}; // BR always
    vecs[1]  = '{16'hC3FE, 1'b1, 1'b0, 3'b001, 16'h0000, 16'h000E, 1'b1}; // B EQ -2, Z=1
    vecs[2]  = '{16'h0000, 1'b1, 1'b0, 3'b001, 16'h0000, 16'h0010, 1'b0}; // ADD, pulse drops
    vecs[3]  = '{16'hC3FE, 1'b1, 1'b0, 3'b000, 16'h0000, 16'h0012, 1'b0}; // B EQ, Z=0
    vecs[4]  = '{16'hDE00, 1'b1, 1'b0, 3'b000, 16'h1235, 16'h1234, 1'b1}; // BR odd cleared
    vecs[5]  = '{16'hDE00, 1'b1, 1'b0, 3'b000, 16'hFFFE, 16'hFFFE, 1'b1};
    vecs[6]  = '{16'hCE01, 1'b1, 1'b0, 3'b000, 16'h0000, 16'h0002, 1'b1}; // wrap +1
    vecs[7]  = '{16'hDE00, 1'b1, 1'b0, 3'b000, 16'hFFFF, 16'hFFFE, 1'b1};
    vecs[8]  = '{16'h0000, 1'b1, 1'b0, 3'bxxx, 16'h0000, 16'h0000, 1'b0}; // ADD wraps, X flags
    vecs[9]  = '{16'hE000, 1'b1, 1'b0, 3'bxxx, 16'h0000, 16'h0002, 1'b0}; // PCS, X flags
    vecs[10] = '{16'hC008, 1'b1, 1'b0, 3'b000, 16'h0000, 16'h0014, 1'b1}; // B NE +8
    vecs[11] = '{16'hC7FB, 1'b1, 1'b0, 3'b010, 16'h0000, 16'h000C, 1'b1}; // B LT -5
    vecs[12] = '{16'hCC05, 1'b1, 1'b0, 3'b001, 16'h0000, 16'h000E, 1'b0}; // B OV, V=0
    vecs[13] = '{16'hDE00, 1'b0, 1'b0, 3'b000, 16'h4444, 16'h000E, 1'b0}; // not valid
    vecs[14] = '{16'hCF00, 1'b1, 1'b0, 3'b000, 16'h0000, 16'hFE10, 1'b1}; // -256 words
    vecs[15] = '{16'hCEFF, 1'b1, 1'b0, 3'b000, 16'h0000, 16'h0010, 1'b1}; // +255 words
    vecs[16] = '{16'hD200, 1'b1, 1'b0, 3'b000, 16'h5555, 16'h0012, 1'b0}; // BR EQ not taken

    rst = 1'b0;
    instr = 16'h0000;
    instr_valid = 1'b0;
    stall = 1'b0;
    flags = 3'b000;
    rs_data = 16'h0000;
    #12;
    rst = 1'b1;
    #1;

    // Move off the reset PC, then reset asynchronously between edges.
    step(16'h0000, 1'b1, 1'b0, 3'b000, 16'h0000);
    step(16'h0000, 1'b1, 1'b0, 3'b000, 16'h0000);
    chk("pre_reset_pc", pc, 16'h0004);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_pc", pc, 16'h0000);
    chk("async_reset_halt", 16'(halt), 16'h0000);
    chk("async_reset_taken", 16'(branch_taken), 16'h0000);
    chk("async_reset_fetch", 16'(fetch_req), 16'h0001);
    #1 rst = 1'b1;

    for (int i = 0; i < 3; i++) step(16'h0000, 1'b1, 1'b0, 3'b000, 16'h0000);
    chk("three_adds_pc", pc, 16'h0006);
    chk("three_adds_taken", 16'(branch_taken), 16'h0000);

    foreach (vecs[i]) begin
      step(vecs[i].instr, vecs[i].valid, vecs[i].stall, vecs[i].flags, vecs[i].rs_data);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_taken", i), 16'(branch_taken), 16'(vecs[i].exp_taken));
      chk($sformatf("vec%0d_pc_plus2", i), pc_plus2, vecs[i].exp_pc + 16'h0002);
      chk($sformatf("vec%0d_fetch", i), 16'(fetch_req), 16'h0001);
    end
    exp_pc = 16'h0012;

    // Condition sweep: B with imm9=+1 lands at pc+4 when taken, pc+2 otherwise.
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        logic t;
        t = cond_ref(3'(c), 3'(f));
        step({4'hC, 3'(c), 9'd1}, 1'b1, 1'b0, 3'(f), 16'h0000);
        exp_pc = exp_pc + (t ? 16'h0004 : 16'h0002);
        chk($sformatf("cc%0d_f%0d_pc", c, f), pc, exp_pc);
        chk($sformatf("cc%0d_f%0d_taken", c, f), 16'(branch_taken), 16'(t));
      end
    end

    // Stall beats instr_valid, even for a taken branch.
    for (int k = 0; k < 3; k++) begin
      step(16'hCE01, 1'b1, 1'b1, 3'b000, 16'h0000);
      chk($sformatf("stall%0d_pc", k), pc, exp_pc);
      chk($sformatf("stall%0d_taken", k), 16'(branch_taken), 16'h0000);
    end
    step(16'h0000, 1'b1, 1'b0, 3'b000, 16'h0000);
    exp_pc = exp_pc + 16'h0002;
    chk("stall_release_pc", pc, exp_pc);

    // Halt at 0x0040, then confirm it is sticky until reset.
    step(16'hDE00, 1'b1, 1'b0, 3'b000, 16'h0040);
    chk("to_0040_pc", pc, 16'h0040);
    step(16'hF000, 1'b1, 1'b0, 3'b000, 16'h0000);
    chk("hlt_pc", pc, 16'h0040);
    chk("hlt_halt", 16'(halt), 16'h0001);
    chk("hlt_fetch", 16'(fetch_req), 16'h0000);
    chk("hlt_taken", 16'(branch_taken), 16'h0000);
    for (int k = 0; k < 3; k++) begin
      step(16'hCE01, 1'b1, 1'b0, 3'b111, 16'h1000);
      chk($sformatf("halted%0d_pc", k), pc, 16'h0040);
      chk($sformatf("halted%0d_halt", k), 16'(halt), 16'h0001);
      chk($sformatf("halted%0d_taken", k), 16'(branch_taken), 16'h0000);
    end
    #2 rst = 1'b0;
    #1;
    chk("halt_reset_pc", pc, 16'h0000);
    chk("halt_reset_halt", 16'(halt), 16'h0000);
    chk("halt_reset_fetch", 16'(fetch_req), 16'h0001);
    #1 rst = 1'b1;
    step(16'h0000, 1'b1, 1'b0, 3'b000, 16'h0000);
    chk("resume_pc", pc, 16'h0002);

    // Reset while stalled also takes effect immediately.
    step(16'h0000, 1'b1, 1'b1, 3'b000, 16'h0000);
    #2 rst = 1'b0;
    #1;
    chk("stall_reset_pc", pc, 16'h0000);
    #1 rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
